regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file for the pipelined RV32I core and its wider variants. It provides N registered read ports, one write port with same-cycle write-to-read bypass, and an optional hardwired-zero register. A synchronous clear sequencer zeroes the array after reset, one entry per cycle, and signals `busy` until the array is valid.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_rd_port.sv | 59 +++++
 rtl/regfile_mp.sv | 98 +++++++++
 tb/tb_regfile_mp.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   rf_state_e : clear/ready sequencer states
//   clog2      : address width from register count
//   RF_XLEN, RF_NREGS : default register width and count
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of regfile_mp.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : array not yet valid; forces output to zero
//   rd_en_i      : load a new value; when low the output holds
//   rd_addr_i    : read address
//   wr_en_i      : a legal write is being committed this cycle
//   wr_addr_i    : address of that write
//   wr_data_i    : data of that write
//   reg_data_i   : array contents at rd_addr_i (pre-write value)
//   rd_data_o    : registered read data
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic [XLEN-1:0] reg_data_i,
    output logic [XLEN-1:0] rd_data_o
);

    logic [XLEN-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (clear_i) begin
            rd_data_d = '0;
        end else if (rd_en_i) begin
            // Zero check wins over bypass so a discarded x0 write never leaks through.
            if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
                rd_data_d = '0;
            end else if ((BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = reg_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write-to-read bypass,
// optional hardwired-zero register and a post-reset clear sequencer.
//   clk     : clock
//   rst     : synchronous active-high reset
//   rd_en   : per-port read enable (NRD bits)
//   rd_addr : packed read addresses, port k at [k*AW +: AW]
//   rd_data : packed registered read data, port k at [k*XLEN +: XLEN]
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   busy    : array is being cleared; reads and writes are ignored
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned NREGS    = RF_NREGS,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    output logic                busy
);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            clr_we;
    logic            wr_ok;
    logic [XLEN-1:0] regs_q [NREGS];

    // Clear sequencer: one entry per cycle, then hand over to normal operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        if (state_q == RF_CLEAR) begin
            clr_we    = 1'b1;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(NREGS - 1)) begin
                state_d = RF_READY;
            end
        end
    end

    assign busy = (state_q == RF_CLEAR);

    assign wr_ok = (state_q == RF_READY) && !rst && wr_en &&
                   ((ZERO_REG == 0) || (wr_addr != '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                regs_q[clr_ptr_q] <= '0;
            end else if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .clk_i      (clk),
            .rst_i      (rst),
            .clear_i    (busy),
            .rd_en_i    (rd_en[k]),
            .rd_addr_i  (rd_addr[k*AW +: AW]),
            .wr_en_i    (wr_ok),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .reg_data_i (regs_q[rd_addr[k*AW +: AW]]),
            .rd_data_o  (rd_data[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic clk;
    logic rst;

    // dut_a: defaults, dut_b: BYPASS=0 ZERO_REG=0 (same stimulus as dut_a)
    logic [1:0]  rd_en_ab;
    logic [9:0]  rd_addr_ab;
    logic        wr_en_ab;
    logic [4:0]  wr_addr_ab;
    logic [31:0] wr_data_ab;
    logic [63:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b;

    // dut_c: XLEN=64, NREGS=16, NRD=3
    logic [2:0]   rd_en_c;
    logic [11:0]  rd_addr_c;
    logic         wr_en_c;
    logic [3:0]   wr_addr_c;
    logic [63:0]  wr_data_c;
    logic [191:0] rd_data_c;
    logic         busy_c;

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en_ab), .rd_addr(rd_addr_ab), .rd_data(rd_data_a),
        .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab), .busy(busy_a)
    );

    regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en_ab), .rd_addr(rd_addr_ab), .rd_data(rd_data_b),
        .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab), .busy(busy_b)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut_c (
        .clk(clk), .rst(rst), .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned sig;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // sig: 0/1 dut_a ports, 2/3 dut_b ports, 4/5/6 dut_c ports
    function automatic logic [63:0] obs(input int unsigned sig);
        case (sig)
            0: obs = {32'h0, rd_data_a[31:0]};
            1: obs = {32'h0, rd_data_a[63:32]};
            2: obs = {32'h0, rd_data_b[31:0]};
            3: obs = {32'h0, rd_data_b[63:32]};
            4: obs = rd_data_c[63:0];
            5: obs = rd_data_c[127:64];
            6: obs = rd_data_c[191:128];
            default: obs = '0;
        endcase
    endfunction

    task automatic push(input int unsigned sig, input logic [63:0] exp, input string name);
        exp_t x;
        x.sig = sig;
        x.exp = exp;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic [1:0] en, input int unsigned a0, input int unsigned a1,
                          input logic we, input int unsigned wa, input logic [31:0] wd);
        rd_en_ab   = en;
        rd_addr_ab = {5'(a1), 5'(a0)};
        wr_en_ab   = we;
        wr_addr_ab = 5'(wa);
        wr_data_ab = wd;
    endtask

    task automatic set_c(input logic [2:0] en, input int unsigned a0, input int unsigned a1,
                         input int unsigned a2, input logic we, input int unsigned wa,
                         input logic [63:0] wd);
        rd_en_c   = en;
        rd_addr_c = {4'(a2), 4'(a1), 4'(a0)};
        wr_en_c   = we;
        wr_addr_c = 4'(wa);
        wr_data_c = wd;
    endtask

    task automatic test_reset();
        int unsigned cnt_a, cnt_b, cnt_c;
        rst = 1'b1;
        set_ab(2'b11, 1, 2, 1'b1, 1, 32'hFFFF_FFFF);
        set_c(3'b111, 1, 2, 3, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) tick();
        for (int unsigned s = 0; s < 7; s++) push(s, 64'h0, "reset_rd_data");
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if (obs(e.sig) !== e.exp) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h, expected %h", e.name, e.sig, obs(e.sig), e.exp);
            end
        end
        n_vec++;
        if ({busy_a, busy_b, busy_c} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_busy: got %b, expected 111", {busy_a, busy_b, busy_c});
        end
        set_ab(2'b00, 0, 0, 1'b0, 0, 32'h0);
        set_c(3'b000, 0, 0, 0, 1'b0, 0, 64'h0);
        rst = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a === 1'b1) cnt_a++;
            if (busy_b === 1'b1) cnt_b++;
            if (busy_c === 1'b1) cnt_c++;
            tick();
        end
        n_vec += 3;
        if (cnt_a != 32) begin n_err++; $display("FAIL clear_busy_a: got %0d cycles, expected 32", cnt_a); end
        if (cnt_b != 32) begin n_err++; $display("FAIL clear_busy_b: got %0d cycles, expected 32", cnt_b); end
        if (cnt_c != 16) begin n_err++; $display("FAIL clear_busy_c: got %0d cycles, expected 16", cnt_c); end
    endtask

    task automatic test_clear_contents();
        for (int unsigned i = 0; i < 32; i++) begin
            set_ab(2'b11, i, 31 - i, 1'b0, 0, 32'h0);
            push(0, 64'h0, "clear_a0"); push(1, 64'h0, "clear_a1");
            push(2, 64'h0, "clear_b0"); push(3, 64'h0, "clear_b1");
            if (i < 16) begin
                set_c(3'b111, i, 15 - i, i, 1'b0, 0, 64'h0);
                push(4, 64'h0, "clear_c0"); push(5, 64'h0, "clear_c1"); push(6, 64'h0, "clear_c2");
            end else begin
                set_c(3'b000, 0, 0, 0, 1'b0, 0, 64'h0);
            end
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.sig) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @%0d: got %h, expected %h", e.name, i, obs(e.sig), e.exp);
                end
            end
        end
        set_c(3'b000, 0, 0, 0, 1'b0, 0, 64'h0);
    endtask

    task automatic test_write_read();
        for (int s = 0; s < 2; s++) begin
            case (s)
                0: set_ab(2'b00, 0, 0, 1'b1, 5, 32'hDEAD_BEEF);
                default: begin
                    set_ab(2'b11, 5, 5, 1'b0, 0, 32'h0);
                    push(0, 64'hDEAD_BEEF, "wr_rd_a0"); push(1, 64'hDEAD_BEEF, "wr_rd_a1");
                    push(2, 64'hDEAD_BEEF, "wr_rd_b0"); push(3, 64'hDEAD_BEEF, "wr_rd_b1");
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.sig) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, obs(e.sig), e.exp);
                end
            end
        end
    endtask

    task automatic test_bypass();
        for (int s = 0; s < 2; s++) begin
            case (s)
                0: begin
                    set_ab(2'b10, 0, 7, 1'b1, 7, 32'h1234_5678);
                    push(1, 64'h1234_5678, "bypass_a1");
                    push(3, 64'h0, "nobypass_old_b1");
                    push(0, 64'hDEAD_BEEF, "bypass_hold_a0");
                end
                default: begin
                    set_ab(2'b10, 0, 7, 1'b0, 0, 32'h0);
                    push(1, 64'h1234_5678, "bypass_next_a1");
                    push(3, 64'h1234_5678, "nobypass_next_b1");
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.sig) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, obs(e.sig), e.exp);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: set_ab(2'b00, 0, 0, 1'b1, 0, 32'hFFFF_FFFF);
                1: begin
                    set_ab(2'b01, 0, 0, 1'b0, 0, 32'h0);
                    push(0, 64'h0, "zero_a0");
                    push(2, 64'hFFFF_FFFF, "nozero_b0");
                end
                2: begin
                    set_ab(2'b01, 0, 0, 1'b1, 0, 32'h2222_2222);
                    push(0, 64'h0, "zero_bypass_a0");
                    push(2, 64'hFFFF_FFFF, "nozero_old_b0");
                end
                default: begin
                    set_ab(2'b01, 0, 0, 1'b0, 0, 32'h0);
                    push(0, 64'h0, "zero_after_a0");
                    push(2, 64'h2222_2222, "nozero_new_b0");
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.sig) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, obs(e.sig), e.exp);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: set_ab(2'b00, 0, 0, 1'b1, 3, 32'hAA);
                1: begin
                    set_ab(2'b01, 3, 0, 1'b0, 0, 32'h0);
                    push(0, 64'hAA, "stall_rd_a0"); push(2, 64'hAA, "stall_rd_b0");
                end
                2: begin
                    set_ab(2'b00, 3, 0, 1'b1, 3, 32'hBB);
                    push(0, 64'hAA, "stall_hold_a0"); push(2, 64'hAA, "stall_hold_b0");
                end
                3, 4: begin
                    set_ab(2'b00, 3, 0, 1'b0, 0, 32'h0);
                    push(0, 64'hAA, "stall_keep_a0"); push(2, 64'hAA, "stall_keep_b0");
                end
                default: begin
                    set_ab(2'b01, 3, 0, 1'b0, 0, 32'h0);
                    push(0, 64'hBB, "stall_resume_a0"); push(2, 64'hBB, "stall_resume_b0");
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.sig) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @%0d: got %h, expected %h", e.name, s, obs(e.sig), e.exp);
                end
            end
        end
    endtask

    task automatic test_sweep();
        set_ab(2'b00, 0, 0, 1'b0, 0, 32'h0);
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: set_c(3'b000, 0, 0, 0, 1'b1, 5, 64'hDEAD_BEEF_CAFE_F00D);
                1: begin
                    set_c(3'b111, 5, 5, 5, 1'b0, 0, 64'h0);
                    push(4, 64'hDEAD_BEEF_CAFE_F00D, "sweep_c0");
                    push(5, 64'hDEAD_BEEF_CAFE_F00D, "sweep_c1");
                    push(6, 64'hDEAD_BEEF_CAFE_F00D, "sweep_c2");
                end
                2: begin
                    set_c(3'b111, 5, 15, 9, 1'b1, 9, 64'h0123_4567_89AB_CDEF);
                    push(4, 64'hDEAD_BEEF_CAFE_F00D, "sweep_mix_c0");
                    push(5, 64'h0, "sweep_top_old_c1");
                    push(6, 64'h0123_4567_89AB_CDEF, "sweep_bypass_c2");
                end
                3: set_c(3'b000, 0, 0, 0, 1'b1, 15, 64'hFFFF_FFFF_FFFF_FFFF);
                default: begin
                    set_c(3'b011, 0, 15, 0, 1'b0, 0, 64'h0);
                    push(4, 64'h0, "sweep_zero_c0");
                    push(5, 64'hFFFF_FFFF_FFFF_FFFF, "sweep_top_c1");
                    push(6, 64'h0123_4567_89AB_CDEF, "sweep_hold_c2");
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.sig) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", e.name, obs(e.sig), e.exp);
                end
            end
        end
        set_c(3'b000, 0, 0, 0, 1'b0, 0, 64'h0);
    endtask

    task automatic test_busy_restart();
        int unsigned cnt_a, cnt_c;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_a = 0; cnt_c = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a === 1'b1) cnt_a++;
            if (busy_c === 1'b1) cnt_c++;
            if (i == 14) begin
                set_ab(2'b00, 0, 0, 1'b1, 4, 32'h55);
                set_c(3'b000, 0, 0, 0, 1'b1, 4, 64'h55);
            end else begin
                set_ab(2'b00, 0, 0, 1'b0, 0, 32'h0);
                set_c(3'b000, 0, 0, 0, 1'b0, 0, 64'h0);
            end
            tick();
        end
        n_vec += 2;
        if (cnt_a != 32) begin n_err++; $display("FAIL restart_busy_a: got %0d cycles, expected 32", cnt_a); end
        if (cnt_c != 16) begin n_err++; $display("FAIL restart_busy_c: got %0d cycles, expected 16", cnt_c); end
        set_ab(2'b11, 4, 4, 1'b0, 0, 32'h0);
        set_c(3'b001, 4, 0, 0, 1'b0, 0, 64'h0);
        push(0, 64'h0, "lost_wr_a0"); push(1, 64'h0, "lost_wr_a1");
        push(2, 64'h0, "lost_wr_b0"); push(4, 64'h0, "lost_wr_c0");
        tick();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if (obs(e.sig) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, obs(e.sig), e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear_contents();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_stall();
        test_sweep();
        test_busy_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
